shift_right_seq: RTL and testbench
==================================

# shift_right_seq

Multi-cycle right shifter for the datapath: the SRL/SRA counterpart of the single-bit left shift used on branch/jump immediates. It accepts an operand and shift amount over a valid/ready handshake and shifts right by up to STEP bits per cycle, zero-filling or sign-filling. It returns the result over a second valid/ready handshake. It sits beside the ALU so that large shifts do not need a full barrel shifter in the critical path.

## Interface
- WIDTH, 32, operand/result width; power of two, at least 8.
- STEP, 4, maximum bits shifted per cycle; power of two, 1..WIDTH/2.
- SW, $clog2(WIDTH), shift-amount width; derived, not overridden.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  WIDTH  operand.
- in_shamt  in  SW  shift amount, 0..WIDTH-1.
- in_arith  in  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- out_data  out  WIDTH  shifted result.
- busy  out  1  high in SHIFT or DONE.

## Operation
- Internal state: acc[WIDTH-1:0], rem[SW-1:0], arith_q, state ∈ {IDLE, SHIFT, DONE}.
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready:
  - acc←in_data, rem←in_shamt, arith_q←in_arith.
  - Next state is SHIFT if in_shamt≠0, else DONE.
- SHIFT: in_ready=0, out_valid=0. Each cycle:
  - Compute s=min(STEP, rem).
  - acc←acc>>s, with the vacated top s bits = acc[WIDTH-1] if arith_q, else 0.
  - rem←rem−s.
  - If rem−s==0, go to DONE; otherwise stay in SHIFT.
- DONE: out_valid=1, out_data=acc, in_ready=0. On out_ready, go to IDLE. Hold acc/out_data stable while out_valid&!out_ready.
- Sign fill uses the current acc MSB. This is equivalent to the original operand MSB because arithmetic fill preserves it.
- out_data equals acc in every state. It is only meaningful while out_valid=1.
- in_data/in_shamt/in_arith are sampled only on the accept edge. Later changes are ignored.
- in_valid while not in IDLE is ignored (no queuing); the requester holds it until in_ready.
- busy = (state≠IDLE).

## Timing
- Reset values: state=IDLE, acc=0, rem=0, arith_q=0. Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
- Reset asserted mid-operation (SHIFT or DONE) aborts immediately. No result is produced and outputs return to reset values asynchronously.
- After reset deasserts, the first accept can occur on the first rising edge.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - 1 cycle if shamt=0.
  - 1+ceil(shamt/STEP) cycles otherwise.
  - Example with STEP=4: shamt=5 → 3 cycles; shamt=31 → 9 cycles.
- Throughput: one result per (latency+1) cycles when out_ready is held high. The DONE→IDLE edge and the next accept edge are distinct; there is no same-cycle turnaround.
- out_ready low in DONE: the block stalls indefinitely with out_valid=1 and out_data unchanged.
- out_ready high outside DONE has no effect.
- Last step: rem<STEP shifts exactly rem bits, never overshooting.
- in_ready and out_valid are never both 1.

## Test plan
- Reset then logical shift, STEP=4: in_data=0xF000_0000, shamt=8, arith=0 → out_data=0x00F0_0000 with out_valid 3 cycles after the accept edge. in_ready stays 0 until the cycle after out_valid&out_ready.
- Arithmetic shift, partial last step: in_data=0x8000_0010, shamt=5, arith=1 → out_data=0xFC00_0000. The sequence takes 2 SHIFT cycles (4 bits, then 1 bit).
- Zero and maximum shift: shamt=0, in_data=0x1234_5678 → out_data=0x1234_5678 with latency 1. Then shamt=31, arith=1, in_data=0x8000_0000 → 0xFFFF_FFFF with latency 9. Same 0x8000_0000 with arith=0 → 0x0000_0001.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_data stay stable. A new in_valid asserted during this time is not accepted. Release out_ready → return to IDLE, then accept the pending request on the next edge.
- Async reset mid-SHIFT: assert rst between clock edges during the 2nd SHIFT cycle of a shamt=20 request → in_ready=1, out_valid=0, out_data=0, busy=0 immediately. No stale result appears after rst deasserts.
- Randomized cross-check, STEP∈{1,4,16}: 1000 random operands, shift amounts and modes with random out_ready stalls. Results must match the >> / >>> reference, and latencies must match the formula above.

Source files
------------

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle right shifter (logical/arithmetic), up to STEP bits per cycle
module shift_right_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_shamt,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    localparam logic [SW-1:0] STEP_W = SW'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [SW-1:0]    r_rem;
    logic             r_arith;
    logic [SW-1:0]    w_s;
    logic [SW-1:0]    w_rem_nx;
    logic             w_fill;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_cand [STEP+1];

    assign w_s      = (r_rem < STEP_W) ? r_rem : STEP_W;
    assign w_rem_nx = r_rem - w_s;
    assign w_fill   = r_arith & r_acc[WIDTH-1];
    assign w_cand[0] = r_acc;

    // Fixed-distance candidates keep the per-cycle shifter a small STEP+1 way mux.
    for (genvar g = 1; g <= STEP; g++) begin : g_cand
        assign w_cand[g] = {{g{w_fill}}, r_acc[WIDTH-1:g]};
    end

    // Pick the candidate matching this cycle's step size.
    always_comb begin
        w_shifted = r_acc;
        for (int k = 1; k <= STEP; k++)
            if (w_s == SW'(k)) w_shifted = w_cand[k];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: zero shift goes straight to DONE, last step lands exactly on rem.
    always_comb begin
        w_next = r_state == S_IDLE  ? (in_valid ? (in_shamt != '0 ? S_SHIFT : S_DONE) : S_IDLE) :
                 r_state == S_SHIFT ? (w_rem_nx == '0 ? S_DONE : S_SHIFT) :
                 r_state == S_DONE  ? (out_ready ? S_IDLE : S_DONE) : S_IDLE;
    end

    // Datapath: load operand on accept, step the shift while in SHIFT, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_rem   <= '0;
            r_arith <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_acc   <= in_data;
            r_rem   <= in_shamt;
            r_arith <= in_arith;
        end else if (r_state == S_SHIFT) begin
            r_acc   <= w_shifted;
            r_rem   <= w_rem_nx;
        end
    end

    // Outputs decoded from state; result is the accumulator itself.
    always_comb begin
        in_ready  = r_state == S_IDLE;
        out_valid = r_state == S_DONE;
        busy      = r_state != S_IDLE;
        out_data  = r_acc;
    end
endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: randomized and directed checks of shift_right_seq for STEP 1, 4 and 16
module tb_shift_right_seq;
    logic        clk;
    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  in_arith;
    logic [2:0]  out_ready;
    logic [31:0] in_data [3];
    logic [4:0]  in_shamt [3];
    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [2:0]  busy;
    wire  [31:0] out_data [3];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        shift_right_seq #(.WIDTH(32), .STEP(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_shamt  (in_shamt[g]),
            .in_arith  (in_arith[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic int step_of(input int idx);
        return idx == 0 ? 1 : (idx == 1 ? 4 : 16);
    endfunction

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic ar);
        logic signed [31:0] sd;
        logic [31:0] r;
        sd = d;
        if (ar) r = sd >>> sh;
        else    r = d >> sh;
        return r;
    endfunction

    function automatic int ref_lat(input int idx, input int sh);
        return sh == 0 ? 1 : 1 + (sh + step_of(idx) - 1) / step_of(idx);
    endfunction

    task automatic start_op(input int idx, input logic [31:0] d, input logic [4:0] sh, input logic ar);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[idx]) begin
            chk("accept_timeout", 64'd0, 64'd1);
            return;
        end
        in_valid[idx] = 1'b1;
        in_data[idx]  = d;
        in_shamt[idx] = sh;
        in_arith[idx] = ar;
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        in_data[idx]  = $urandom;
        in_shamt[idx] = 5'($urandom);
        in_arith[idx] = 1'($urandom);
    endtask

    task automatic wait_done(input int idx, input logic [31:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            chk("busy_flags", {62'd0, in_ready[idx], busy[idx]}, 64'd1);
        end while (!out_valid[idx] && lat < 100);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("data", {32'd0, out_data[idx]}, {32'd0, exp});
    endtask

    task automatic handshake(input int idx, input int stall, input logic [31:0] exp);
        out_ready[idx] = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold", {31'd0, out_valid[idx], out_data[idx]}, {31'd0, 1'b1, exp});
        end
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
        @(negedge clk);
        chk("release", {61'd0, in_ready[idx], out_valid[idx], busy[idx]}, 64'b100);
    endtask

    task automatic run_op(input int idx, input logic [31:0] d, input int sh, input logic ar, input int stall);
        logic [31:0] e;
        e = ref_shift(d, sh, ar);
        start_op(idx, d, 5'(sh), ar);
        wait_done(idx, e, ref_lat(idx, sh));
        handshake(idx, stall, e);
    endtask

    initial begin
        logic [31:0] e;
        logic        seen;
        rst       = 1'b1;
        in_valid  = '0;
        in_arith  = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            in_data[i]  = '0;
            in_shamt[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk("reset", {29'd0, in_ready[i], out_valid[i], busy[i], out_data[i]}, {29'd0, 3'b100, 32'd0});
        rst = 1'b0;

        run_op(1, 32'hF000_0000, 8, 1'b0, 0);
        run_op(1, 32'h8000_0010, 5, 1'b1, 1);
        run_op(1, 32'h1234_5678, 0, 1'b0, 0);
        run_op(1, 32'h8000_0000, 31, 1'b1, 0);
        run_op(1, 32'h8000_0000, 31, 1'b0, 2);

        e = ref_shift(32'hA5A5_0F0F, 4, 1'b1);
        start_op(1, 32'hA5A5_0F0F, 5'd4, 1'b1);
        wait_done(1, e, ref_lat(1, 4));
        in_valid[1] = 1'b1;
        in_data[1]  = 32'h8765_4321;
        in_shamt[1] = 5'd12;
        in_arith[1] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {30'd0, in_ready[1], out_valid[1], out_data[1]}, {30'd0, 2'b01, e});
        end
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
        @(negedge clk);
        chk("bp_idle", {62'd0, in_ready[1], out_valid[1]}, 64'b10);
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        e = ref_shift(32'h8765_4321, 12, 1'b0);
        wait_done(1, e, ref_lat(1, 12));
        handshake(1, 0, e);

        start_op(1, 32'hDEAD_BEEF, 5'd20, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {29'd0, in_ready[1], out_valid[1], busy[1], out_data[1]}, {29'd0, 3'b100, 32'd0});
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        out_ready[1] = 1'b1;
        repeat (12) begin
            @(negedge clk);
            seen = seen | out_valid[1] | busy[1];
        end
        out_ready[1] = 1'b0;
        chk("no_stale", {63'd0, seen}, 64'd0);

        for (int i = 0; i < 1000; i++)
            run_op(i % 3, $urandom, int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
